// File: rtl/cvp14_mem_responder_if.sv
// Memory-bus bundle between the CVP14 core, the preload host and the memory responder.
interface cvp14_mem_responder_if;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic        V;
    logic [15:0] CoreData;
    logic [15:0] DataIn;
    logic        HostValid;
    logic [15:0] HostAddr;
    logic [15:0] HostData;
    logic        HostReady;
    logic        HostIdle;
    logic [7:0]  OvfCount;
    logic [1:0]  ErrFlags;

    modport master (
        output Addr, RD, WR, V, CoreData, HostValid, HostAddr, HostData,
        input  DataIn, HostReady, HostIdle, OvfCount, ErrFlags
    );

    modport slave (
        input  Addr, RD, WR, V, CoreData, HostValid, HostAddr, HostData,
        output DataIn, HostReady, HostIdle, OvfCount, ErrFlags
    );
endinterface

// File: rtl/cvp14_mem_responder.sv
// Single-port word memory for the CVP14 core with a low-priority host preload FIFO
// that drains only on idle bus cycles, plus overflow counting and sticky error flags.
module cvp14_mem_responder #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 Clk1,
    input  logic                 Reset,
    cvp14_mem_responder_if.slave bus
);
    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam int              MEM_WORDS = 2 ** ADDR_W;
    localparam logic [PTR_W:0]  CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    logic [15:0]       mem       [MEM_WORDS];
    logic [15:0]       fifo_addr [FIFO_DEPTH];
    logic [15:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic [15:0]       head_addr;
    logic [15:0]       head_data;
    logic              core_oor;
    logic              head_oor;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [15:0]       arr_wdata;

    assign core_oor   = (bus.Addr >> ADDR_W) != 16'd0;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign head_oor   = (head_addr >> ADDR_W) != 16'd0;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);

    assign bus.HostReady = !fifo_full && !Reset;
    assign bus.HostIdle  = fifo_empty;

    assign push = bus.HostValid && bus.HostReady;
    // Host entries only get the array on cycles the core leaves completely idle.
    assign pop  = !Reset && !bus.RD && !bus.WR && !fifo_empty;

    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = bus.Addr[ADDR_W-1:0];
        arr_wdata = bus.CoreData;
        if (!Reset) begin
            if (bus.WR && !bus.RD) begin
                arr_we = !core_oor;
            end else if (pop) begin
                arr_we    = !head_oor;
                arr_waddr = head_addr[ADDR_W-1:0];
                arr_wdata = head_data;
            end
        end
    end

    always_ff @(posedge Clk1) begin
        if (arr_we) begin
            mem[arr_waddr] <= arr_wdata;
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            bus.DataIn <= 16'h0000;
        end else if (bus.RD) begin
            bus.DataIn <= core_oor ? 16'h0000 : mem[bus.Addr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge Clk1) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.HostAddr;
            fifo_data[wr_ptr] <= bus.HostData;
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            bus.OvfCount <= 8'd0;
            bus.ErrFlags <= 2'b00;
        end else begin
            if (bus.V && (bus.OvfCount != 8'hFF)) begin
                bus.OvfCount <= bus.OvfCount + 8'd1;
            end
            if (((bus.RD || bus.WR) && core_oor) || (pop && head_oor)) begin
                bus.ErrFlags[0] <= 1'b1;
            end
            if (bus.RD && bus.WR) begin
                bus.ErrFlags[1] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Bench for cvp14_mem_responder: directed scenarios plus random traffic checked
// every cycle against a queue/array model of the memory and host FIFO.
module tb_cvp14_mem_responder;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int MEM_WORDS  = 2 ** ADDR_W;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } host_wr_t;

    logic Clk1;
    logic Reset;
    cvp14_mem_responder_if bus ();

    cvp14_mem_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .Clk1  (Clk1),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    logic [15:0] m_mem [MEM_WORDS];
    host_wr_t    m_q[$];
    logic [15:0] m_di;
    int          m_ovf;
    logic [1:0]  m_err;

    // Bench-side record of what the array should hold, for the literal checks
    logic [15:0] pre [MEM_WORDS];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk1) begin
        bit       can_push;
        host_wr_t e;
        can_push = m_q.size() < FIFO_DEPTH;
        if (Reset) begin
            m_di  = 16'h0000;
            m_q.delete();
            m_ovf = 0;
            m_err = 2'b00;
        end else begin
            if (bus.RD) begin
                if (int'(bus.Addr) >= MEM_WORDS) begin
                    m_di     = 16'h0000;
                    m_err[0] = 1'b1;
                end else begin
                    m_di = m_mem[int'(bus.Addr)];
                end
                if (bus.WR) m_err[1] = 1'b1;
            end else if (bus.WR) begin
                if (int'(bus.Addr) >= MEM_WORDS) m_err[0] = 1'b1;
                else m_mem[int'(bus.Addr)] = bus.CoreData;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                if (int'(e.a) >= MEM_WORDS) m_err[0] = 1'b1;
                else m_mem[int'(e.a)] = e.d;
            end
            if (bus.HostValid && can_push) begin
                e.a = bus.HostAddr;
                e.d = bus.HostData;
                m_q.push_back(e);
            end
            if (bus.V && m_ovf < 255) m_ovf++;
        end
    end

    always @(negedge Clk1) begin
        if (chk_en) begin
            check("DataIn",    bus.DataIn,    m_di);
            check("OvfCount",  16'(bus.OvfCount), 16'(m_ovf));
            check("ErrFlags",  16'(bus.ErrFlags), 16'(m_err));
            check("HostReady", 16'(bus.HostReady), 16'((m_q.size() < FIFO_DEPTH) && !Reset));
            check("HostIdle",  16'(bus.HostIdle),  16'(m_q.size() == 0));
        end
    end

    task automatic cyc();
        @(posedge Clk1);
        #1;
    endtask

    task automatic host_push(input logic [15:0] a, input logic [15:0] d);
        bit acc;
        int guard;
        bus.HostValid = 1'b1;
        bus.HostAddr  = a;
        bus.HostData  = d;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            @(negedge Clk1);
            acc = bus.HostReady;
            cyc();
            guard++;
        end
        if (!acc) check("host_push_timeout", 16'd0, 16'd1);
        bus.HostValid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!bus.HostIdle && guard < 20) begin
            cyc();
            guard++;
        end
        check("wait_idle", 16'(bus.HostIdle), 16'd1);
    endtask

    task automatic core_read(input logic [15:0] a);
        bus.RD   = 1'b1;
        bus.WR   = 1'b0;
        bus.Addr = a;
        cyc();
        bus.RD   = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        Reset         = 1'b1;
        bus.Addr      = 16'h0000;
        bus.RD        = 1'b0;
        bus.WR        = 1'b0;
        bus.V         = 1'b0;
        bus.CoreData  = 16'h0000;
        bus.HostValid = 1'b0;
        bus.HostAddr  = 16'h0000;
        bus.HostData  = 16'h0000;
        cyc();
        cyc();
        chk_en = 1'b1;
        check("rst_DataIn",    bus.DataIn, 16'h0000);
        check("rst_HostReady", 16'(bus.HostReady), 16'd0);
        check("rst_HostIdle",  16'(bus.HostIdle), 16'd1);
        check("rst_OvfCount",  16'(bus.OvfCount), 16'd0);
        check("rst_ErrFlags",  16'(bus.ErrFlags), 16'd0);
        Reset = 1'b0;
        cyc();

        // Preload every word through the host FIFO so the whole array is known
        for (int i = 0; i < MEM_WORDS; i++) begin
            d      = 16'($urandom);
            pre[i] = d;
            host_push(16'(i), d);
        end
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            core_read(16'(i));
            check("preload_rd", bus.DataIn, pre[i]);
        end
        check("preload_err", 16'(bus.ErrFlags), 16'd0);

        // Backpressure: RD held, 5 push attempts, only 4 accepted
        bus.RD   = 1'b1;
        bus.Addr = 16'h0005;
        for (int k = 0; k < 5; k++) begin
            d             = 16'($urandom);
            bus.HostValid = 1'b1;
            bus.HostAddr  = 16'h0100 + 16'(k);
            bus.HostData  = d;
            @(negedge Clk1);
            check("bp_ready", 16'(bus.HostReady), 16'(k < 4));
            if (k < 4) pre[16'h0100 + k] = d;
            cyc();
        end
        bus.HostValid = 1'b0;
        cyc();
        cyc();
        check("bp_not_idle", 16'(bus.HostIdle), 16'd0);
        bus.RD = 1'b0;
        cyc();
        check("bp_ready_after_pop", 16'(bus.HostReady), 16'd1);
        cyc();
        cyc();
        check("bp_idle_3", 16'(bus.HostIdle), 16'd0);
        cyc();
        check("bp_idle_4", 16'(bus.HostIdle), 16'd1);
        for (int k = 0; k < 4; k++) begin
            core_read(16'h0100 + 16'(k));
            check("bp_rd", bus.DataIn, pre[16'h0100 + k]);
        end

        // Write then read back, DataIn holds through idle cycles
        bus.WR       = 1'b1;
        bus.Addr     = 16'h0010;
        bus.CoreData = 16'hBEEF;
        cyc();
        bus.WR = 1'b0;
        pre[16'h0010] = 16'hBEEF;
        core_read(16'h0010);
        check("wr_rd", bus.DataIn, 16'hBEEF);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("wr_rd_hold", bus.DataIn, 16'hBEEF);
        end

        // Out-of-range read and RD+WR collision
        core_read(16'h0400);
        check("oor_data", bus.DataIn, 16'h0000);
        check("oor_flag", 16'(bus.ErrFlags[0]), 16'd1);
        bus.RD       = 1'b1;
        bus.WR       = 1'b1;
        bus.Addr     = 16'h0020;
        bus.CoreData = 16'h1234;
        cyc();
        bus.WR = 1'b0;
        check("rdwr_data", bus.DataIn, pre[16'h0020]);
        check("rdwr_flags", 16'(bus.ErrFlags), 16'd3);
        core_read(16'h0020);
        check("rdwr_kept", bus.DataIn, pre[16'h0020]);

        // Overflow counter saturation and reset
        bus.V = 1'b1;
        repeat (300) cyc();
        check("ovf_sat", 16'(bus.OvfCount), 16'd255);
        bus.V = 1'b0;
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("ovf_rst", 16'(bus.OvfCount), 16'd0);
        check("err_rst", 16'(bus.ErrFlags), 16'd0);

        // Reset with pending host writes and an in-flight read
        bus.RD   = 1'b1;
        bus.Addr = 16'h0040;
        for (int k = 0; k < 3; k++) host_push(16'h0030 + 16'(k), 16'hA500 + 16'(k));
        Reset = 1'b1;
        cyc();
        Reset  = 1'b0;
        bus.RD = 1'b0;
        check("midrst_idle", 16'(bus.HostIdle), 16'd1);
        check("midrst_data", bus.DataIn, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            core_read(16'h0030 + 16'(k));
            check("midrst_rd", bus.DataIn, pre[16'h0030 + k]);
        end
        core_read(16'h0010);
        check("midrst_keep", bus.DataIn, 16'hBEEF);

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            Reset         = ($urandom_range(0, 299) == 0);
            bus.RD        = ($urandom_range(0, 9) < 3);
            bus.WR        = ($urandom_range(0, 9) < 3);
            bus.V         = ($urandom_range(0, 3) == 0);
            bus.Addr      = ($urandom_range(0, 15) == 0) ? (16'h0400 | 16'($urandom))
                                                         : 16'($urandom_range(0, 63));
            bus.CoreData  = 16'($urandom);
            bus.HostValid = ($urandom_range(0, 1) == 1);
            bus.HostAddr  = ($urandom_range(0, 15) == 0) ? (16'h0800 | 16'($urandom))
                                                         : 16'($urandom_range(0, 63));
            bus.HostData  = 16'($urandom);
            cyc();
        end
        Reset         = 1'b0;
        bus.RD        = 1'b0;
        bus.WR        = 1'b0;
        bus.V         = 1'b0;
        bus.HostValid = 1'b0;
        repeat (8) cyc();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
